// File: rtl/cpu_common_pkg.sv
// Shared CPU types: op_type codes, decoded instruction layout and the
// EX issue controller state encoding.
package cpu_common;

    typedef enum logic [3:0] {
        OP_ALU, OP_BRANCH, OP_LOAD, OP_STORE, OP_MUL, OP_DIV, OP_CSR
    } op_type_e;

    typedef struct packed {
        logic       valid;
        logic [5:0] cause;
    } exception_t;

    typedef struct packed {
        op_type_e   op_type;
        exception_t exception;
        logic [4:0] rd;
        logic [31:0] imm;
    } decoded_instr_t;

    typedef enum logic [2:0] {
        EMPTY, FULL, MD_REQ, MD_WAIT, DRAIN
    } ex_ctrl_state_e;

    // A MUL/DIV that already carries an exception never reaches the MD unit.
    function automatic logic needs_md(decoded_instr_t i);
        return ((i.op_type == OP_MUL) || (i.op_type == OP_DIV)) && !i.exception.valid;
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ex_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_value,
    output logic         o_saturated
);
    logic [W-1:0] r_cnt;

    assign o_value     = r_cnt;
    assign o_saturated = &r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                       r_cnt <= '0;
        else if (i_clr)                  r_cnt <= '0;
        else if (i_inc && !o_saturated)  r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/ex_issue_ctrl.sv
// EX issue controller: operand registers, decode/stage-2 flow control and
// MUL/DIV sequencing. Define EX_STALL_CNT_EN to build the decode stall counter.
module ex_issue_ctrl
    import cpu_common::*;
#(
    parameter int MD_TIMEOUT  = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   de_valid_i,
    output logic                   de_ready_o,
    input  decoded_instr_t         de_instr_i,
    input  logic [63:0]            de_rs1_i,
    input  logic [63:0]            de_rs2_i,
    output decoded_instr_t         ex_instr_o,
    output logic [63:0]            ex_rs1_o,
    output logic [63:0]            ex_rs2_o,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic                   md_req_valid_o,
    input  logic                   md_req_ready_i,
    input  logic                   md_resp_valid_i,
    output logic                   md_timeout_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);
    localparam int WD_W = (MD_TIMEOUT > 0) ? $clog2(MD_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIM    = WD_W'(MD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIM_M1 = WD_W'(MD_TIMEOUT - 1);
    localparam bit WD_EN = (MD_TIMEOUT != 0);

    ex_ctrl_state_e r_state, w_state_nxt;
    logic           w_accept, w_load_md;
    logic           r_timeout;
    logic [WD_W-1:0] w_wd_cnt;
    logic           w_wd_sat, w_wd_inc, w_wd_clr;

    assign w_accept  = de_valid_i && de_ready_o && !flush_i;
    assign w_load_md = needs_md(de_instr_i);

    always_comb begin
        de_ready_o     = 1'b0;
        wb_valid_o     = 1'b0;
        md_req_valid_o = 1'b0;
        w_state_nxt    = r_state;
        unique case (r_state)
            EMPTY:   de_ready_o = 1'b1;
            FULL: begin
                wb_valid_o = 1'b1;
                de_ready_o = wb_ready_i;
            end
            MD_REQ:  md_req_valid_o = 1'b1;
            default: ;
        endcase

        if (flush_i) begin
            unique case (r_state)
                MD_REQ:  w_state_nxt = md_req_ready_i  ? DRAIN : EMPTY;
                MD_WAIT: w_state_nxt = md_resp_valid_i ? EMPTY : DRAIN;
                DRAIN:   w_state_nxt = md_resp_valid_i ? EMPTY : DRAIN;
                default: w_state_nxt = EMPTY;
            endcase
        end else begin
            unique case (r_state)
                EMPTY:   if (w_accept) w_state_nxt = w_load_md ? MD_REQ : FULL;
                FULL:    if (w_accept)        w_state_nxt = w_load_md ? MD_REQ : FULL;
                         else if (wb_ready_i) w_state_nxt = EMPTY;
                MD_REQ:  if (md_req_ready_i)  w_state_nxt = MD_WAIT;
                MD_WAIT: if (md_resp_valid_i) w_state_nxt = FULL;
                DRAIN:   if (md_resp_valid_i) w_state_nxt = EMPTY;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= EMPTY;
            ex_instr_o <= '0;
            ex_rs1_o   <= '0;
            ex_rs2_o   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                ex_instr_o <= de_instr_i;
                ex_rs1_o   <= de_rs1_i;
                ex_rs2_o   <= de_rs2_i;
            end
        end
    end

    // Restart the watchdog whenever the MD unit takes a request, including
    // a request that is flushed in the same cycle straight into DRAIN.
    assign w_wd_clr = (r_state == MD_REQ) &&
                      ((w_state_nxt == MD_WAIT) || (w_state_nxt == DRAIN));
    assign w_wd_inc = WD_EN && ((r_state == MD_WAIT) || (r_state == DRAIN)) &&
                      (w_wd_cnt != WD_LIM) && !w_wd_sat;

    ex_sat_counter #(.W(WD_W)) u_wd_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .i_inc      (w_wd_inc),
        .i_clr      (w_wd_clr),
        .o_value    (w_wd_cnt),
        .o_saturated(w_wd_sat)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                     r_timeout <= 1'b0;
        else if (w_wd_inc && !w_wd_clr && (w_wd_cnt == WD_LIM_M1)) r_timeout <= 1'b1;
    end
    assign md_timeout_o = r_timeout;

`ifdef EX_STALL_CNT_EN
    logic w_stall_inc, w_stall_sat;
    assign w_stall_inc = de_valid_i && !de_ready_o && !flush_i && !w_stall_sat;

    ex_sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .i_inc      (w_stall_inc),
        .i_clr      (1'b0),
        .o_value    (stall_cnt_o),
        .o_saturated(w_stall_sat)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Scoreboard bench for ex_issue_ctrl: stimulus pushes expected retiring rs1
// values, a monitor pops them on every wb handshake.
module tb_ex_issue_ctrl;
    import cpu_common::*;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           flush_i = 1'b0;
    logic           de_valid_i = 1'b0;
    logic           de_ready_o;
    decoded_instr_t de_instr_i = '0;
    logic [63:0]    de_rs1_i = '0, de_rs2_i = '0;
    decoded_instr_t ex_instr_o;
    logic [63:0]    ex_rs1_o, ex_rs2_o;
    logic           wb_valid_o;
    logic           wb_ready_i = 1'b0;
    logic           md_req_valid_o;
    logic           md_req_ready_i = 1'b0;
    logic           md_resp_valid_i = 1'b0;
    logic           md_timeout_o;
    logic [31:0]    stall_cnt_o;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    ex_issue_ctrl #(.MD_TIMEOUT(8), .STALL_CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .flush_i(flush_i),
        .de_valid_i(de_valid_i), .de_ready_o(de_ready_o), .de_instr_i(de_instr_i),
        .de_rs1_i(de_rs1_i), .de_rs2_i(de_rs2_i),
        .ex_instr_o(ex_instr_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .md_req_valid_o(md_req_valid_o), .md_req_ready_i(md_req_ready_i),
        .md_resp_valid_i(md_resp_valid_i), .md_timeout_o(md_timeout_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive point: just after the active edge.
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Sample point: opposite edge.
    task automatic smp();
        @(negedge clk);
    endtask

    function automatic decoded_instr_t mk(input op_type_e op, input logic exc, input logic [4:0] rd);
        decoded_instr_t d;
        d = '0;
        d.op_type = op;
        d.exception.valid = exc;
        d.rd = rd;
        d.imm = {27'd0, rd};
        return d;
    endfunction

    task automatic offer(input op_type_e op, input logic exc, input logic [63:0] rs1);
        de_valid_i = 1'b1;
        de_instr_i = mk(op, exc, rs1[4:0]);
        de_rs1_i   = rs1;
        de_rs2_i   = ~rs1;
    endtask

    // Monitor: every stage-2 handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && wb_valid_o && wb_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL retire: unexpected retire rs1=0x%0h, expected none", ex_rs1_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (ex_rs1_o !== e || ex_rs2_o !== ~e) begin
                    failures++;
                    $display("FAIL retire: got rs1=0x%0h rs2=0x%0h expected rs1=0x%0h rs2=0x%0h",
                             ex_rs1_o, ex_rs2_o, e, ~e);
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_de_ready", de_ready_o, 1);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_md_req", md_req_valid_o, 0);
        chk("rst_timeout", md_timeout_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_ex_rs1", ex_rs1_o, 0);
        @(negedge clk); rstn = 1'b1;
        cyc();

        // Three back-to-back ALU ops
        wb_ready_i = 1'b1;
        offer(OP_ALU, 1'b0, 64'h11); exp_q.push_back(64'h11);
        smp(); chk("b2b_ready0", de_ready_o, 1);
        cyc(); offer(OP_ALU, 1'b0, 64'h22); exp_q.push_back(64'h22);
        smp(); chk("b2b_ready1", de_ready_o, 1); chk("b2b_valid1", wb_valid_o, 1);
        cyc(); offer(OP_ALU, 1'b0, 64'h33); exp_q.push_back(64'h33);
        smp(); chk("b2b_ready2", de_ready_o, 1); chk("b2b_valid2", wb_valid_o, 1);
        cyc(); de_valid_i = 1'b0;
        smp(); chk("b2b_valid3", wb_valid_o, 1);
        cyc(); smp(); chk("b2b_empty", wb_valid_o, 0);
        chk("b2b_drained", exp_q.size(), 0);

        // Held op with stage 2 stalled for 4 cycles
        cyc(); wb_ready_i = 1'b0;
        offer(OP_ALU, 1'b0, 64'h1234); exp_q.push_back(64'h1234);
        for (int i = 0; i < 4; i++) begin
            cyc(); offer(OP_ALU, 1'b0, 64'h5555);
            smp(); chk("hold_rs1", ex_rs1_o, 64'h1234); chk("hold_ready", de_ready_o, 0);
        end
        cyc(); de_valid_i = 1'b0; wb_ready_i = 1'b1;
`ifdef EX_STALL_CNT_EN
        smp(); chk("stall_cnt", stall_cnt_o, 4);
`else
        smp(); chk("stall_cnt", stall_cnt_o, 0);
`endif
        cyc(); smp(); chk("hold_empty", wb_valid_o, 0);

        // MUL, request accepted after 2 cycles, response 5 cycles later
        cyc(); offer(OP_MUL, 1'b0, 64'hAA); exp_q.push_back(64'hAA);
        for (int i = 0; i < 3; i++) begin
            cyc(); de_valid_i = 1'b0; md_req_ready_i = (i == 2);
            smp(); chk("mul_req", md_req_valid_o, 1); chk("mul_req_ready", de_ready_o, 0);
            chk("mul_req_wb", wb_valid_o, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(); md_req_ready_i = 1'b0; md_resp_valid_i = (i == 4);
            smp(); chk("mul_wait_req", md_req_valid_o, 0); chk("mul_wait_wb", wb_valid_o, 0);
        end
        cyc(); md_resp_valid_i = 1'b0;
        smp(); chk("mul_result", wb_valid_o, 1);
        cyc(); smp(); chk("mul_done", wb_valid_o, 0);

        // MUL with exception bypasses the MD unit
        cyc(); offer(OP_MUL, 1'b1, 64'hE1); exp_q.push_back(64'hE1);
        cyc(); de_valid_i = 1'b0;
        smp(); chk("exc_wb", wb_valid_o, 1); chk("exc_md_req", md_req_valid_o, 0);
        cyc();

        // Flush in MD_WAIT, response 3 cycles later is dropped
        offer(OP_MUL, 1'b0, 64'hBB);
        cyc(); de_valid_i = 1'b0; md_req_ready_i = 1'b1;
        cyc(); md_req_ready_i = 1'b0; flush_i = 1'b1;
        cyc(); flush_i = 1'b0;
        smp(); chk("drain_ready", de_ready_o, 0); chk("drain_wb", wb_valid_o, 0);
        cyc();
        cyc(); md_resp_valid_i = 1'b1;
        smp(); chk("drain_ready2", de_ready_o, 0);
        cyc(); md_resp_valid_i = 1'b0;
        smp(); chk("drain_exit_ready", de_ready_o, 1); chk("drain_exit_wb", wb_valid_o, 0);

        // Flush with md_req_ready_i -> DRAIN
        cyc(); offer(OP_DIV, 1'b0, 64'hCC);
        cyc(); de_valid_i = 1'b0; md_req_ready_i = 1'b1; flush_i = 1'b1;
        cyc(); md_req_ready_i = 1'b0; flush_i = 1'b0;
        smp(); chk("req_flush_ready", de_ready_o, 0); chk("req_flush_md", md_req_valid_o, 0);
        cyc(); md_resp_valid_i = 1'b1;
        cyc(); md_resp_valid_i = 1'b0;
        smp(); chk("req_flush_exit", de_ready_o, 1);

        // Flush with response in MD_WAIT -> EMPTY directly
        cyc(); offer(OP_DIV, 1'b0, 64'hDD);
        cyc(); de_valid_i = 1'b0; md_req_ready_i = 1'b1;
        cyc(); md_req_ready_i = 1'b0; flush_i = 1'b1; md_resp_valid_i = 1'b1;
        cyc(); flush_i = 1'b0; md_resp_valid_i = 1'b0;
        smp(); chk("resp_flush_ready", de_ready_o, 1); chk("resp_flush_wb", wb_valid_o, 0);

        // Watchdog: no response
        cyc(); offer(OP_MUL, 1'b0, 64'hEE);
        cyc(); de_valid_i = 1'b0; md_req_ready_i = 1'b1;
        cyc(); md_req_ready_i = 1'b0;
        smp(); chk("wd_enter", md_timeout_o, 0);
        for (int i = 0; i < 7; i++) cyc();
        smp(); chk("wd_before", md_timeout_o, 0);
        cyc(); smp(); chk("wd_fire", md_timeout_o, 1);
        for (int i = 0; i < 3; i++) cyc();
        smp(); chk("wd_sticky", md_timeout_o, 1); chk("wd_no_wb", wb_valid_o, 0);

        // Asynchronous reset mid-operation
        #2 rstn = 1'b0;
        #1 chk("arst_timeout", md_timeout_o, 0); chk("arst_ready", de_ready_o, 1);
        cyc(); rstn = 1'b1; md_resp_valid_i = 1'b1;
        cyc(); md_resp_valid_i = 1'b0;
        smp(); chk("arst_resp_ignored", wb_valid_o, 0); chk("arst_ready2", de_ready_o, 1);
        cyc();

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
